element_cmd_sched: RTL and testbench

//  Timed command scheduler in front of one wave element. Buffers {time, 64-bit command} pairs
//  in a FIFO, runs a local time counter, and drives the element's command/cstrobe pins exactly

---
 rtl/element_cmd_sched.sv | 91 +++++++++
 tb/tb_element_cmd_sched.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/element_cmd_sched.sv
// element_cmd_sched: timed FIFO of {time, command} pairs issued to a wave element when the local time counter reaches each timestamp
module element_cmd_sched #(
  parameter int DEPTH = 8,
  parameter int TW = 32,
  parameter int CW = 64,
  parameter int SW = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sync,
  input  logic                     flush,
  input  logic [CW-1:0]            cmd_in,
  input  logic [TW-1:0]            cmd_time,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  output logic [CW-1:0]            command,
  output logic                     cstrobe,
  input  logic                     collision,
  output logic [TW-1:0]            tnow,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     late,
  output logic [SW-1:0]            late_cnt,
  output logic [SW-1:0]            coll_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cmd_mem [DEPTH];
  logic [TW-1:0] time_mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [TW-1:0] tnow_q, tnow_d, diff;
  logic [CW-1:0] command_q, command_d;
  logic cstrobe_q, cstrobe_d, late_q, late_d;
  logic [SW-1:0] late_cnt_q, late_cnt_d, coll_cnt_q, coll_cnt_d;
  logic empty, full, push, pop, is_late;
  always_comb begin
    count = wr_q - rd_q;
    empty = wr_q == rd_q;
    full = count == (AW+1)'(DEPTH);
    diff = time_mem[rd_q[AW-1:0]] - tnow_q;
    is_late = diff[TW-1];
    // no compare during ISSUE keeps strobes at least one cycle apart
    pop = state_q != ISSUE && !empty && (diff == '0 || is_late);
    push = cmd_valid && !full && !flush;
    wr_d = wr_q + (AW+1)'(push);
    rd_d = flush ? wr_q : rd_q + (AW+1)'(pop);
    state_d = pop ? ISSUE : (wr_d != rd_d ? WAIT : IDLE);
    tnow_d = sync ? '0 : tnow_q + TW'(1);
    command_d = pop ? cmd_mem[rd_q[AW-1:0]] : command_q;
    cstrobe_d = pop;
    late_d = pop && is_late;
    late_cnt_d = late_cnt_q + SW'(pop && is_late && !(&late_cnt_q));
    coll_cnt_d = coll_cnt_q + SW'(collision && !(&coll_cnt_q));
  end
  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem[wr_q[AW-1:0]] <= cmd_in;
      time_mem[wr_q[AW-1:0]] <= cmd_time;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      tnow_q <= '0;
      command_q <= '0;
      cstrobe_q <= 1'b0;
      late_q <= 1'b0;
      late_cnt_q <= '0;
      coll_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      tnow_q <= tnow_d;
      command_q <= command_d;
      cstrobe_q <= cstrobe_d;
      late_q <= late_d;
      late_cnt_q <= late_cnt_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end
  assign cmd_ready = !full;
  assign command = command_q;
  assign cstrobe = cstrobe_q;
  assign tnow = tnow_q;
  assign late = late_q;
  assign late_cnt = late_cnt_q;
  assign coll_cnt = coll_cnt_q;
endmodule

// File: tb/tb_element_cmd_sched.sv
// tb_element_cmd_sched: directed checks of the command scheduler; TW=12 so the time wrap is reachable quickly
module tb_element_cmd_sched;
  localparam int TW = 12;
  logic clk = 0, reset = 1, sync = 0, flush = 0, cmd_valid = 0, collision = 0;
  logic [63:0] cmd_in = '0;
  logic [TW-1:0] cmd_time = '0;
  logic cmd_ready, cstrobe, late;
  logic [63:0] command;
  logic [TW-1:0] tnow;
  logic [3:0] count;
  logic [7:0] late_cnt, coll_cnt;
  int total = 0, bad = 0;
  element_cmd_sched #(.DEPTH(8), .TW(TW), .CW(64), .SW(8)) dut (
    .clk(clk), .reset(reset), .sync(sync), .flush(flush), .cmd_in(cmd_in),
    .cmd_time(cmd_time), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .command(command), .cstrobe(cstrobe), .collision(collision), .tnow(tnow),
    .count(count), .late(late), .late_cnt(late_cnt), .coll_cnt(coll_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [TW-1:0] t, input logic [63:0] c);
    cmd_valid = 1;
    cmd_time = t;
    cmd_in = c;
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic wait_tnow(input logic [TW-1:0] v);
    int n = 0;
    while (tnow != v && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_tnow", tnow, v);
  endtask
  task automatic wait_strobe(input string tag, input int max);
    int n = 0;
    while (!cstrobe && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, cstrobe, 1);
  endtask
  task automatic no_strobe(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      seen += int'(cstrobe);
    end
    chk(tag, seen, 0);
  endtask
  initial begin
    logic [TW-1:0] w;
    repeat (2) @(negedge clk);
    chk("rst_tnow", tnow, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_command", command, 0);
    chk("rst_cstrobe", cstrobe, 0);
    chk("rst_late", late, 0);
    chk("rst_late_cnt", late_cnt, 0);
    chk("rst_coll_cnt", coll_cnt, 0);
    reset = 0;
    wait_tnow(10);
    push(100, 64'hA);
    wait_strobe("t1", 200);
    chk("t1_tnow", tnow, 101);
    chk("t1_cmd", command, 64'hA);
    chk("t1_late", late, 0);
    @(negedge clk);
    chk("t1_single", cstrobe, 0);
    chk("t1_hold", command, 64'hA);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t2_ready%0d", i), cmd_ready, i < 8);
      push(TW'(1000 + 2 * i), 64'h100 + 64'(i));
    end
    chk("t2_count", count, 8);
    for (int i = 0; i < 8; i++) begin
      wait_strobe($sformatf("t2_s%0d", i), 1000);
      chk($sformatf("t2_tnow%0d", i), tnow, TW'(1001 + 2 * i));
      chk($sformatf("t2_cmd%0d", i), command, 64'h100 + 64'(i));
      chk($sformatf("t2_late%0d", i), late, 0);
      @(negedge clk);
      chk($sformatf("t2_gap%0d", i), cstrobe, 0);
    end
    no_strobe("t2_no9th", 20);
    chk("t2_empty", count, 0);
    w = tnow;
    push(5, 64'h55);
    wait_strobe("t3", 10);
    chk("t3_tnow", tnow, w + TW'(2));
    chk("t3_late", late, 1);
    chk("t3_late_cnt", late_cnt, 1);
    sync = 1;
    @(negedge clk);
    sync = 0;
    chk("t5_sync", tnow, 0);
    for (int i = 0; i < 3; i++) push(200, 64'h200 + 64'(i));
    for (int i = 0; i < 3; i++) begin
      wait_strobe($sformatf("t5_s%0d", i), 300);
      chk($sformatf("t5_tnow%0d", i), tnow, TW'(201 + 2 * i));
      chk($sformatf("t5_cmd%0d", i), command, 64'h200 + 64'(i));
      chk($sformatf("t5_late%0d", i), late, i > 0);
      @(negedge clk);
    end
    chk("t5_late_cnt", late_cnt, 3);
    wait_tnow(4093);
    push(2, 64'h44);
    wait_strobe("t4", 20);
    chk("t4_tnow", tnow, 3);
    chk("t4_cmd", command, 64'h44);
    chk("t4_late", late, 0);
    @(negedge clk);
    w = tnow;
    for (int i = 0; i < 4; i++) push(w + TW'(100 + i), 64'h600 + 64'(i));
    chk("t6_count4", count, 4);
    flush = 1;
    cmd_valid = 1;
    cmd_time = w + TW'(110);
    cmd_in = 64'h6FF;
    @(negedge clk);
    flush = 0;
    cmd_valid = 0;
    chk("t6_flush_count", count, 0);
    no_strobe("t6_flush_quiet", 150);
    chk("t6_late_cnt_kept", late_cnt, 3);
    push(tnow + TW'(30), 64'h77);
    chk("t6_count1", count, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_tnow", tnow, 0);
    chk("t6_rst_cmd", command, 0);
    chk("t6_rst_late_cnt", late_cnt, 0);
    no_strobe("t6_rst_quiet", 300);
    collision = 1;
    repeat (5) @(negedge clk);
    chk("t6_coll5", coll_cnt, 5);
    repeat (295) @(negedge clk);
    collision = 0;
    chk("t6_coll_sat", coll_cnt, 255);
    @(negedge clk);
    chk("t6_coll_hold", coll_cnt, 255);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
